product_bcd_converter: RTL
==========================

PRODUCT_BCD_CONVERTER -- requirements
Module: product_bcd_converter

Interface
REQ-001 Parameter IN_W, default 8, binary product width; 8 is the only supported value.
REQ-002 Parameter DIGITS, default 3, BCD output digit count; 3 is the only supported value.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  product word present from the upstream 4x4 array multiplier.
REQ-006 in_ready  output  1  converter can accept a product.
REQ-007 product  input  8  unsigned binary product, 0..255; 0..225 from the multiplier.
REQ-008 out_valid  output  1  BCD result available.
REQ-009 out_ready  input  1  downstream (display driver) accepts the result.
REQ-010 bcd_hundreds  output  4  hundreds digit, 0..2.
REQ-011 bcd_tens  output  4  tens digit, 0..9.
REQ-012 bcd_ones  output  4  ones digit, 0..9.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE; any illegal encoding SHALL return to IDLE on the next edge.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are registered-state decodes.
REQ-015 Accept: IDLE with in_valid=1 SHALL, on the edge, latch product into the shift register, clear the BCD scratch digits, clear the shift counter, and enter SHIFT.
REQ-016 In IDLE with in_valid=0, state SHALL hold and no register SHALL change.
REQ-017 Each SHIFT edge SHALL add 3 to every scratch digit that is >= 5, then shift {digits, binary} left by one bit, then increment the counter.
REQ-018 The 8th SHIFT edge (counter = 7) SHALL load bcd_hundreds/tens/ones with the corrected-and-shifted digits and enter DONE.
REQ-019 Latency: out_valid SHALL rise exactly 8 clock edges after the accept edge.
REQ-020 DONE SHALL hold bcd_* and out_valid stable while out_ready=0, for unlimited cycles.
REQ-021 DONE with out_ready=1 SHALL return to IDLE on the edge; bcd_* SHALL retain the last result until the next load.
REQ-022 in_valid and product SHALL be ignored outside IDLE; upstream changes during SHIFT/DONE SHALL NOT affect the result.
REQ-023 The handshake SHALL NOT admit a new product on the same edge as the out handshake; the minimum initiation interval is 10 cycles.
REQ-024 Result SHALL equal the decimal expansion of product for all 256 inputs: hundreds*100 + tens*10 + ones = product.
REQ-025 out_ready while not in DONE SHALL have no effect.

Reset
REQ-026 rst=1 SHALL, asynchronously, force IDLE, the counter to 0, the shift/scratch registers to 0, and bcd_* to 0; in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-027 rst asserted mid-SHIFT or in DONE SHALL abort the conversion and discard the pending result; no out_valid pulse SHALL follow.
REQ-028 After rst deasserts, the first rising edge with in_valid=1 SHALL be a legal accept.

Structure
REQ-029 A shared package SHALL hold the FSM state encodings (IDLE, SHIFT, DONE), IN_W, DIGITS and the shift count constant (= IN_W).
REQ-030 One sub-module, bcd_add3_correct (4-bit in, 4-bit out, +3 when >= 5), SHALL be instantiated once per digit.
REQ-031 Counter width SHALL be 3 bits; no latches and no combinational path from in_valid to in_ready or from out_ready to out_valid.

Verification
REQ-032 After reset, drive product=225 (A=15, B=15) with in_valid=1 for one cycle -> out_valid rises 8 edges after accept; digits are 2,2,5.
REQ-033 Drive products 0, 9, 10, 99, 100 and 255 in sequence with out_ready=1 -> digits are 0,0,0 / 0,0,9 / 0,1,0 / 0,9,9 / 1,0,0 / 2,5,5, and in_ready is low during each conversion.
REQ-034 Convert 144, then hold out_ready=0 for 20 cycles while toggling in_valid and product=7 -> outputs stay 1,4,4 with out_valid=1, in_ready=0, and 7 is not accepted.
REQ-035 Assert rst on the 4th SHIFT edge of product=200 -> outputs go to 0 immediately, no out_valid follows, and the next accept of 37 yields 0,3,7.
REQ-036 Run an exhaustive sweep of A,B in 0..15 through the multiplier into the converter with randomized out_ready -> every result matches the A*B decimal expansion and no result is dropped or duplicated.

Source files
------------

// File: rtl/product_bcd_converter_pkg.sv
// Shared constants and FSM encoding for the
// product-to-BCD double-dabble converter.
package product_bcd_converter_pkg;

  localparam int IN_W      = 8;
  localparam int DIGITS    = 3;
  localparam int SHIFT_CNT = IN_W;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/product_bcd_converter_add3.sv
// Double-dabble digit correction: adds 3 to a BCD
// digit that is 5 or more before the next shift.
module bcd_add3_correct (
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  import product_bcd_converter_pkg::*;

  always_comb begin
    fixed = digit;
    if (digit >= 4'd5) fixed = digit + 4'd3;
  end

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential binary-to-BCD converter for an 8-bit
// multiplier product, valid/ready on both sides.
module product_bcd_converter #(
  parameter int IN_W   = product_bcd_converter_pkg::IN_W,
  parameter int DIGITS = product_bcd_converter_pkg::DIGITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] product,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      bcd_hundreds,
  output logic [3:0]      bcd_tens,
  output logic [3:0]      bcd_ones
);

  import product_bcd_converter_pkg::*;

  localparam int BCD_W = DIGITS * 4;
  localparam int TOT_W = BCD_W + IN_W;
  localparam logic [2:0] LAST = 3'(SHIFT_CNT - 1);

  state_t state, state_n;

  logic [2:0]       cnt;
  logic [IN_W-1:0]  bin;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] corr;
  logic [BCD_W-1:0] result;
  logic [TOT_W-1:0] shifted;

  for (genvar i = 0; i < DIGITS; i++) begin : g_fix
    bcd_add3_correct u_fix (
      .digit (scratch[i*4 +: 4]),
      .fixed (corr[i*4 +: 4])
    );
  end

  assign shifted = {corr, bin} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = SHIFT;
      SHIFT:   if (cnt == LAST) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bin     <= '0;
      scratch <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin     <= product;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          bin     <= shifted[IN_W-1:0];
          scratch <= shifted[TOT_W-1:IN_W];
          cnt     <= cnt + 3'd1;
          if (cnt == LAST) result <= shifted[TOT_W-1:IN_W];
        end
        default: ;
      endcase
    end
  end

  // Handshake flags decode registered state only.
  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign bcd_hundreds = result[11:8];
  assign bcd_tens     = result[7:4];
  assign bcd_ones     = result[3:0];

endmodule
